// File: rtl/alici.sv
// Frame receiver: accepts either a whole parallel word in one strobe or a
// serial frame of N/3 three-bit characters, most significant first.
module alici #(
  parameter int N           = 30,
  parameter int ZAMAN_ASIMI = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         basla,
  input  logic         mod,
  input  logic         gecerli,
  input  logic [N-1:0] gelen_veri,
  output logic [N-1:0] alinan_veri,
  output logic         hazir,
  output logic         mesgul,
  output logic         hata
);

  localparam int         CHARS   = N / 3;
  localparam logic [4:0] CNT_TOP = 5'(CHARS - 1);
  localparam logic [7:0] IDLE_LIM = 8'(ZAMAN_ASIMI);

  typedef enum logic {BOS, AL} state_t;

  state_t         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [7:0]     idle_q, idle_d;
  logic [N-1:0]   buf_q, buf_d;
  logic [N-1:0]   word_d;
  logic           hazir_d, hata_d;

  function automatic logic [N-1:0] put_char(input logic [N-1:0] w,
                                            input logic [4:0]   idx,
                                            input logic [2:0]   c);
    logic [N-1:0] r;
    r = w;
    r[int'(idx)*3 +: 3] = c;
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    buf_d   = buf_q;
    word_d  = alinan_veri;
    hazir_d = 1'b0;
    hata_d  = 1'b0;
    if (basla) begin
      // A strobe always opens a fresh frame; one already in flight is dropped.
      if (state_q == AL) hata_d = 1'b1;
      idle_d  = '0;
      cnt_d   = CNT_TOP;
      buf_d   = '0;
      state_d = BOS;
      if (!mod) begin
        word_d  = gelen_veri;
        hazir_d = 1'b1;
      end else begin
        state_d = AL;
        if (gecerli) begin
          buf_d = put_char('0, CNT_TOP, gelen_veri[2:0]);
          if (CNT_TOP == 5'd0) begin
            word_d  = buf_d;
            hazir_d = 1'b1;
            state_d = BOS;
          end else begin
            cnt_d = CNT_TOP - 5'd1;
          end
        end
      end
    end else if (state_q == AL) begin
      if (gecerli) begin
        buf_d  = put_char(buf_q, cnt_q, gelen_veri[2:0]);
        idle_d = '0;
        if (cnt_q == 5'd0) begin
          word_d  = buf_d;
          hazir_d = 1'b1;
          state_d = BOS;
          cnt_d   = CNT_TOP;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end else begin
        idle_d = idle_q + 8'd1;
        if (idle_d == IDLE_LIM) begin
          hata_d  = 1'b1;
          state_d = BOS;
          cnt_d   = CNT_TOP;
          idle_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= BOS;
      cnt_q       <= CNT_TOP;
      idle_q      <= '0;
      buf_q       <= '0;
      alinan_veri <= '0;
      hazir       <= 1'b0;
      hata        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      buf_q       <= buf_d;
      alinan_veri <= word_d;
      hazir       <= hazir_d;
      hata        <= hata_d;
    end
  end

  assign mesgul = (state_q == AL);

endmodule

// File: tb/tb_alici.sv
// Bench for alici: directed frames with literal expectations plus randomized
// traffic compared every cycle against a character-queue model.
module tb_alici;

  localparam int N  = 30;
  localparam int ZA = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         basla = 1'b0;
  logic         mod = 1'b0;
  logic         gecerli = 1'b0;
  logic [N-1:0] gelen_veri = '0;
  logic [N-1:0] alinan_veri;
  logic         hazir, mesgul, hata;

  int total = 0;
  int bad   = 0;

  alici #(.N(N), .ZAMAN_ASIMI(ZA)) dut (
    .clk(clk), .rst(rst), .basla(basla), .mod(mod), .gecerli(gecerli),
    .gelen_veri(gelen_veri), .alinan_veri(alinan_veri), .hazir(hazir),
    .mesgul(mesgul), .hata(hata)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [2:0]   m_chars[$];
  bit           m_busy;
  int           m_idle;
  logic [N-1:0] m_word;
  bit           m_hazir, m_hata;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_chars.delete();
      m_busy = 0; m_idle = 0; m_word = '0; m_hazir = 0; m_hata = 0;
    end else begin
      m_hazir = 0;
      m_hata  = 0;
      if (basla) begin
        if (m_busy) m_hata = 1;
        m_chars.delete();
        m_idle = 0;
        if (!mod) begin
          m_word = gelen_veri; m_hazir = 1; m_busy = 0;
        end else begin
          m_busy = 1;
          if (gecerli) m_chars.push_back(gelen_veri[2:0]);
        end
      end else if (m_busy) begin
        if (gecerli) begin
          m_chars.push_back(gelen_veri[2:0]);
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == ZA) begin m_hata = 1; m_busy = 0; end
        end
      end
      if (m_busy && m_chars.size() == N/3) begin
        logic [N-1:0] w;
        w = '0;
        for (int k = 0; k < N/3; k++) w = w | (N'(m_chars[k]) << (N - 3 - 3*k));
        m_word = w; m_hazir = 1; m_busy = 0;
        m_chars.delete();
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_alinan", 64'(alinan_veri), 64'(m_word));
    chk("cyc_hazir",  64'(hazir),       64'(m_hazir));
    chk("cyc_hata",   64'(hata),        64'(m_hata));
    chk("cyc_mesgul", 64'(mesgul),      64'(m_busy));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      basla = 0; gecerli = 0; gelen_veri = N'($urandom); step();
    end
  endtask

  task automatic send_par(input logic [N-1:0] w);
    basla = 1; mod = 0; gecerli = 0; gelen_veri = w; step();
    basla = 0;
  endtask

  task automatic ser_char(input logic [2:0] c, input bit first, input int gap);
    idle_cyc(gap);
    basla = first; mod = 1; gecerli = 1;
    gelen_veri = (N'($urandom) & ~N'(7)) | N'(c);
    step();
    basla = 0; gecerli = 0;
  endtask

  logic [2:0]   seq [10];
  logic [N-1:0] exp_w;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    #12;
    chk("rst_alinan", 64'(alinan_veri), 64'h0);
    chk("rst_hazir",  64'(hazir), 64'h0);
    chk("rst_mesgul", 64'(mesgul), 64'h0);
    chk("rst_hata",   64'(hata), 64'h0);
    step(); rst = 1; idle_cyc(2);

    // Parallel word
    send_par(30'h2345_6789);
    chk("par_alinan", 64'(alinan_veri), 64'h2345_6789);
    chk("par_hazir",  64'(hazir), 64'h1);
    chk("par_mesgul", 64'(mesgul), 64'h0);
    idle_cyc(1);
    chk("par_hazir_drop", 64'(hazir), 64'h0);
    chk("par_hold", 64'(alinan_veri), 64'h2345_6789);

    // Back-to-back serial frame
    for (int k = 0; k < 10; k++) begin
      ser_char(seq[k], k == 0, 0);
      if (k < 9) chk("ser_busy", 64'(mesgul), 64'h1);
    end
    chk("ser_alinan", 64'(alinan_veri), 64'(30'o1234567012));
    chk("ser_hazir",  64'(hazir), 64'h1);
    chk("ser_mesgul", 64'(mesgul), 64'h0);
    idle_cyc(2);

    // Same frame with 3-cycle gaps
    send_par(30'h0);
    for (int k = 0; k < 10; k++) begin
      ser_char(seq[k], k == 0, (k == 0) ? 0 : 3);
      chk("gap_hata", 64'(hata), 64'h0);
    end
    chk("gap_alinan", 64'(alinan_veri), 64'(30'o1234567012));
    chk("gap_hazir",  64'(hazir), 64'h1);
    idle_cyc(2);

    // Timeout after four characters
    send_par(30'h1ABC_DEF0);
    for (int k = 0; k < 4; k++) ser_char(seq[k], k == 0, 0);
    idle_cyc(ZA - 1);
    chk("to_early_hata", 64'(hata), 64'h0);
    chk("to_early_busy", 64'(mesgul), 64'h1);
    idle_cyc(1);
    chk("to_hata",   64'(hata), 64'h1);
    chk("to_mesgul", 64'(mesgul), 64'h0);
    chk("to_hazir",  64'(hazir), 64'h0);
    chk("to_alinan", 64'(alinan_veri), 64'h1ABC_DEF0);
    idle_cyc(2);

    // Parallel restart on top of a serial frame
    for (int k = 0; k < 5; k++) ser_char(seq[k], k == 0, 0);
    send_par(30'h0000_00FF);
    chk("rs_hata",   64'(hata), 64'h1);
    chk("rs_hazir",  64'(hazir), 64'h1);
    chk("rs_alinan", 64'(alinan_veri), 64'hFF);
    idle_cyc(2);

    // Asynchronous reset while character 6 is presented
    for (int k = 0; k < 5; k++) ser_char(seq[k], k == 0, 0);
    basla = 0; mod = 1; gecerli = 1; gelen_veri = N'(3'd6);
    #2 rst = 0;
    #1;
    chk("ar_alinan", 64'(alinan_veri), 64'h0);
    chk("ar_hazir",  64'(hazir), 64'h0);
    chk("ar_hata",   64'(hata), 64'h0);
    chk("ar_mesgul", 64'(mesgul), 64'h0);
    step(); gecerli = 0; step();
    rst = 1; idle_cyc(1);
    exp_w = '0;
    for (int k = 0; k < 10; k++) begin
      logic [2:0] c;
      c = 3'($urandom);
      exp_w = exp_w | (N'(c) << (N - 3 - 3*k));
      ser_char(c, k == 0, 0);
    end
    chk("ar_after_alinan", 64'(alinan_veri), 64'(exp_w));
    chk("ar_after_hazir",  64'(hazir), 64'h1);
    idle_cyc(2);

    // Randomized traffic with varying character density
    for (int blk = 0; blk < 6; blk++) begin
      int pv;
      pv = (blk % 3 == 0) ? 90 : ((blk % 3 == 1) ? 50 : 4);
      for (int i = 0; i < 500; i++) begin
        basla      = ($urandom_range(99) < 4);
        mod        = ($urandom_range(99) < 75);
        gecerli    = ($urandom_range(99) < pv);
        gelen_veri = N'($urandom);
        step();
      end
    end
    idle_cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
